// File: rtl/hook_motion_ctrl_if.sv
// hook_motion_ctrl_if: control/status bundle between the game logic and the hook controller
interface hook_motion_ctrl_if;
  logic       run;
  logic       step_tick;
  logic       fire;
  logic       hit_item;
  logic [1:0] item_weight;
  logic       counter_en;
  logic [3:0] angle_idx;
  logic [7:0] rope_len;
  logic [1:0] hook_state;
  logic       grab_done;
  logic [1:0] grab_weight;
  modport master (
    output run, step_tick, fire, hit_item, item_weight,
    input  counter_en, angle_idx, rope_len, hook_state, grab_done, grab_weight
  );
  modport slave (
    input  run, step_tick, fire, hit_item, item_weight,
    output counter_en, angle_idx, rope_len, hook_state, grab_done, grab_weight
  );
endinterface

// File: rtl/hook_motion_ctrl.sv
// hook_motion_ctrl: swings, extends and retracts the miner's hook on animation step edges
module hook_motion_ctrl #(
  parameter int unsigned ANGLE_MAX = 12,
  parameter int unsigned LEN_MIN   = 8,
  parameter int unsigned LEN_MAX   = 200,
  parameter int unsigned EXT_STEP  = 4,
  parameter int unsigned RET_STEP  = 8
) (
  input logic clk,
  input logic resetn,
  hook_motion_ctrl_if.slave bus
);
  typedef enum logic [1:0] {SWING, EXTEND, RETRACT, SCORE} state_t;
  state_t     state, state_n;
  logic [3:0] angle, angle_n;
  logic       dir_up, dir_n;
  logic [7:0] len, len_n;
  logic       grabbed, grabbed_n;
  logic [1:0] wgt, wgt_n;
  logic       step_q, fire_q, step, fire_edge;
  logic       counter_en, grab_done, grab_done_n;
  logic [1:0] grab_weight;
  logic       at_top, at_bot;
  logic [3:0] swing_angle;
  logic [8:0] len_add, rsh, rstep, len_sub;
  logic [7:0] ext_len, ret_len;
  assign step      = bus.step_tick & ~step_q;
  assign fire_edge = bus.fire & ~fire_q;
  assign at_top      = dir_up && angle == 4'(ANGLE_MAX);
  assign at_bot      = !dir_up && angle == 4'd0;
  assign swing_angle = at_top ? 4'(ANGLE_MAX - 1) : at_bot ? 4'd1 : dir_up ? angle + 4'd1 : angle - 4'd1;
  assign len_add = {1'b0, len} + 9'(EXT_STEP);
  assign ext_len = len_add > 9'(LEN_MAX) ? 8'(LEN_MAX) : len_add[7:0];
  assign rsh     = 9'(RET_STEP) >> wgt;
  assign rstep   = rsh == 9'd0 ? 9'd1 : rsh;
  assign len_sub = {1'b0, len} - rstep;
  assign ret_len = {1'b0, len} < rstep + 9'(LEN_MIN) ? 8'(LEN_MIN) : len_sub[7:0];
  assign bus.counter_en  = counter_en;
  assign bus.angle_idx   = angle;
  assign bus.rope_len    = len;
  assign bus.hook_state  = state;
  assign bus.grab_done   = grab_done;
  assign bus.grab_weight = grab_weight;
  // next-state: motion only advances while run is high; edges seen while frozen are lost
  always_comb begin
    state_n     = state;
    angle_n     = angle;
    dir_n       = dir_up;
    len_n       = len;
    grabbed_n   = grabbed;
    wgt_n       = wgt;
    grab_done_n = 1'b0;
    if (bus.run) begin
      case (state)
        SWING: begin
          if (fire_edge) state_n = EXTEND;
          else if (step) begin
            angle_n = swing_angle;
            dir_n   = (at_top || at_bot) ? ~dir_up : dir_up;
          end
        end
        EXTEND: begin
          if (bus.hit_item) begin
            wgt_n     = bus.item_weight;
            grabbed_n = 1'b1;
            state_n   = RETRACT;
          end else if (len == 8'(LEN_MAX)) begin
            grabbed_n = 1'b0;
            state_n   = RETRACT;
          end else if (step) len_n = ext_len;
        end
        RETRACT: begin
          if (len == 8'(LEN_MIN)) begin
            state_n     = grabbed ? SCORE : SWING;
            grab_done_n = grabbed;
          end else if (step) len_n = ret_len;
        end
        default: begin
          grabbed_n = 1'b0;
          state_n   = SWING;
        end
      endcase
    end
  end
  // state, edge history and reporting registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= SWING;
      angle       <= 4'(ANGLE_MAX / 2);
      dir_up      <= 1'b1;
      len         <= 8'(LEN_MIN);
      grabbed     <= 1'b0;
      wgt         <= 2'd0;
      step_q      <= 1'b0;
      fire_q      <= 1'b0;
      counter_en  <= 1'b0;
      grab_done   <= 1'b0;
      grab_weight <= 2'd0;
    end else begin
      state       <= state_n;
      angle       <= angle_n;
      dir_up      <= dir_n;
      len         <= len_n;
      grabbed     <= grabbed_n;
      wgt         <= wgt_n;
      step_q      <= bus.step_tick;
      fire_q      <= bus.fire;
      counter_en  <= bus.run;
      grab_done   <= grab_done_n;
      grab_weight <= grab_done_n ? wgt : grab_weight;
    end
  end
endmodule

// File: tb/tb_hook_motion_ctrl.sv
// tb_hook_motion_ctrl: directed stimulus with a scoreboard of expected hook motion and grab events
module tb_hook_motion_ctrl;
  logic clk, resetn;
  int   errors = 0;
  int   checks = 0;
  logic mon_on = 1'b0;
  logic [13:0] exp_q[$];
  logic [1:0]  grab_q[$];
  logic [13:0] prev = {2'd0, 4'd6, 8'd8};
  logic [3:0]  ang_tbl [14] = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd11,
                                4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
  hook_motion_ctrl_if bus();
  hook_motion_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] s, input logic [3:0] a, input logic [7:0] l);
    exp_q.push_back({s, a, l});
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_step();
    bus.step_tick = 1'b1;
    @(posedge clk);
    #1 bus.step_tick = 1'b0;
    cycles(1);
  endtask
  task automatic pulse_fire();
    bus.fire = 1'b1;
    @(posedge clk);
    #1 bus.fire = 1'b0;
    cycles(1);
  endtask
  // monitor: every visible change of {state, angle, length} must match the next expected tuple
  always @(negedge clk) begin
    if (mon_on) begin
      logic [13:0] cur;
      cur = {bus.hook_state, bus.angle_idx, bus.rope_len};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL motion_unexpected: got state/angle/len 0x%0h with nothing expected", cur);
        end else check("motion state/angle/len", 32'(cur), 32'(exp_q.pop_front()));
        prev = cur;
      end
      if (bus.grab_done === 1'b1) begin
        if (grab_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grab_unexpected: got grab_done=1 weight=%0d with no grab expected", bus.grab_weight);
        end else begin
          check("grab_weight", 32'(bus.grab_weight), 32'(grab_q.pop_front()));
          check("grab_in_score", 32'(bus.hook_state), 32'd3);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
  initial begin
    resetn = 1'b1;
    bus.run = 1'b0;
    bus.step_tick = 1'b0;
    bus.fire = 1'b0;
    bus.hit_item = 1'b0;
    bus.item_weight = 2'd0;
    #3 resetn = 1'b0;
    #1;
    check("reset_state", 32'(bus.hook_state), 32'd0);
    check("reset_angle", 32'(bus.angle_idx), 32'd6);
    check("reset_len", 32'(bus.rope_len), 32'd8);
    check("reset_counter_en", 32'(bus.counter_en), 32'd0);
    check("reset_grab_done", 32'(bus.grab_done), 32'd0);
    check("reset_grab_weight", 32'(bus.grab_weight), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    cycles(1);
    mon_on = 1'b1;
    bus.run = 1'b1;
    @(negedge clk);
    check("counter_en_delay", 32'(bus.counter_en), 32'd0);
    @(posedge clk);
    #1 check("counter_en_on", 32'(bus.counter_en), 32'd1);
    for (int i = 0; i < 14; i++) begin
      push(2'd0, ang_tbl[i], 8'd8);
      pulse_step();
    end
    push(2'd0, 4'd3, 8'd8);
    bus.step_tick = 1'b1;
    cycles(500);
    bus.step_tick = 1'b0;
    cycles(2);
    push(2'd1, 4'd3, 8'd8);
    pulse_fire();
    for (int i = 1; i <= 48; i++) begin
      push(2'd1, 4'd3, 8'(8 + 4 * i));
      if (i == 48) push(2'd2, 4'd3, 8'd200);
      pulse_step();
      if (i == 20) pulse_fire();
    end
    for (int i = 1; i <= 24; i++) begin
      push(2'd2, 4'd3, 8'(200 - 8 * i));
      if (i == 24) push(2'd0, 4'd3, 8'd8);
      pulse_step();
      if (i == 10) pulse_fire();
    end
    cycles(2);
    push(2'd1, 4'd3, 8'd8);
    pulse_fire();
    for (int i = 1; i <= 10; i++) begin
      push(2'd1, 4'd3, 8'(8 + 4 * i));
      pulse_step();
    end
    push(2'd2, 4'd3, 8'd48);
    bus.hit_item = 1'b1;
    bus.item_weight = 2'd2;
    cycles(1);
    bus.hit_item = 1'b0;
    bus.item_weight = 2'd0;
    for (int i = 1; i <= 20; i++) begin
      push(2'd2, 4'd3, 8'(48 - 2 * i));
      if (i == 20) begin
        push(2'd3, 4'd3, 8'd8);
        push(2'd0, 4'd3, 8'd8);
        grab_q.push_back(2'd2);
      end
      pulse_step();
    end
    cycles(2);
    check("grab_weight_held_2", 32'(bus.grab_weight), 32'd2);
    bus.hit_item = 1'b1;
    bus.item_weight = 2'd1;
    cycles(3);
    bus.hit_item = 1'b0;
    bus.item_weight = 2'd0;
    push(2'd1, 4'd3, 8'd8);
    pulse_fire();
    for (int i = 1; i <= 47; i++) begin
      push(2'd1, 4'd3, 8'(8 + 4 * i));
      pulse_step();
    end
    push(2'd1, 4'd3, 8'd200);
    push(2'd2, 4'd3, 8'd200);
    bus.step_tick = 1'b1;
    @(posedge clk);
    #1 bus.step_tick = 1'b0;
    bus.hit_item = 1'b1;
    bus.item_weight = 2'd3;
    cycles(1);
    bus.hit_item = 1'b0;
    bus.item_weight = 2'd0;
    for (int i = 1; i <= 192; i++) begin
      push(2'd2, 4'd3, 8'(200 - i));
      if (i == 192) begin
        push(2'd3, 4'd3, 8'd8);
        push(2'd0, 4'd3, 8'd8);
        grab_q.push_back(2'd3);
      end
      pulse_step();
      if (i == 5) pulse_fire();
    end
    cycles(2);
    check("grab_weight_held_3", 32'(bus.grab_weight), 32'd3);
    push(2'd1, 4'd3, 8'd8);
    pulse_fire();
    push(2'd1, 4'd3, 8'd12);
    pulse_step();
    push(2'd1, 4'd3, 8'd16);
    pulse_step();
    push(2'd2, 4'd3, 8'd16);
    bus.hit_item = 1'b1;
    cycles(1);
    bus.hit_item = 1'b0;
    bus.run = 1'b0;
    cycles(1);
    check("counter_en_off", 32'(bus.counter_en), 32'd0);
    repeat (3) pulse_step();
    pulse_fire();
    check("frozen_state", 32'(bus.hook_state), 32'd2);
    check("frozen_len", 32'(bus.rope_len), 32'd16);
    bus.run = 1'b1;
    cycles(1);
    check("counter_en_resume", 32'(bus.counter_en), 32'd1);
    push(2'd2, 4'd3, 8'd8);
    push(2'd3, 4'd3, 8'd8);
    push(2'd0, 4'd3, 8'd8);
    grab_q.push_back(2'd0);
    pulse_step();
    cycles(2);
    check("grab_weight_held_0", 32'(bus.grab_weight), 32'd0);
    push(2'd1, 4'd3, 8'd8);
    pulse_fire();
    for (int i = 1; i <= 3; i++) begin
      push(2'd1, 4'd3, 8'(8 + 4 * i));
      pulse_step();
    end
    push(2'd0, 4'd6, 8'd8);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_state", 32'(bus.hook_state), 32'd0);
    check("async_reset_angle", 32'(bus.angle_idx), 32'd6);
    check("async_reset_len", 32'(bus.rope_len), 32'd8);
    check("async_reset_counter_en", 32'(bus.counter_en), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    cycles(3);
    check("counter_en_after_reset", 32'(bus.counter_en), 32'd1);
    push(2'd0, 4'd7, 8'd8);
    pulse_step();
    cycles(3);
    check("motion_queue_drained", 32'(exp_q.size()), 32'd0);
    check("grab_queue_drained", 32'(grab_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
